xtone_gen: RTL
==============

Name: xtone_gen

Overview:
- Memory-mapped square-wave tone generator; downstream consumer of note data produced by the sequencer loop controller and the controller data bus.
- Turns each written (half-period, duration) pair into a square wave on snd_out for a timed interval.
- Holds a one-entry pending-note buffer so the sequencer can queue the next note while the current one plays; busy/queue status is readable by software.

Parameters:
DATA_W, 32, controller data bus width
DIV_W, 24, half-period counter width in clock cycles
DUR_W, 16, duration counter width in ticks
TICK_DIV, 50000, clock cycles per duration tick (1 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (rst=0 resets)
sel  in  1  block select from address decoder
we  in  1  write enable, qualified by sel
addr  in  2  register offset: 0 HALF_PERIOD(W), 1 DURATION/start(W), 2 STATUS(R), 3 CTRL(W)
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data; combinational, 0 when not (sel & ~we)
snd_out  out  1  square-wave audio output
busy  out  1  high while a note is playing

Behaviour:
- Reset (async, rst=0): snd_out=0, busy=0, state IDLE, hp_stage=0, pending_valid=0, ovf=0, all counters 0. Deasserting reset mid-note leaves block idle; the interrupted note is lost.
- Write addr0: hp_stage <= data_in[DIV_W-1:0] (upper bits ignored). Has no effect on a note already playing.
- Write addr1 forms note = {hp_stage, data_in[DUR_W-1:0]}:
  - duration 0: write ignored; no state change, ovf unchanged.
  - IDLE: load note, go PLAY. busy=1 from the next cycle. Phase and tick counters cleared, snd_out=0.
  - PLAY, pending_valid=0: pending <= note, pending_valid=1.
  - PLAY, pending_valid=1: note dropped, ovf <= 1 (sticky).
- Write addr3 with data_in[0]=1: abort. Go IDLE next cycle, busy=0, snd_out=0, pending_valid=0. data_in[0]=0 has no effect.
- Read addr2: data_out = {zeros, ovf, pending_valid, busy} (bits 2:0). The read clears ovf at the clock edge. If ovf is set again in the same cycle, set wins. Reads of addr0/1/3 return 0.
- FSM has two states, IDLE and PLAY.
  - IDLE: counters held at 0, snd_out=0.
  - PLAY phase counter: counts 0..hp-1; on reaching hp-1, toggles snd_out and wraps to 0.
  - hp=0 is a rest: snd_out held 0, duration still counts.
  - hp=1 toggles snd_out every cycle.
  - PLAY tick prescaler: counts 0..TICK_DIV-1; on wrap, remaining <= remaining-1.
  - End of note (tick wrap with remaining==1): if pending_valid, load pending next cycle, clear pending_valid, reset phase/tick counters, snd_out=0, stay PLAY (busy stays 1). Otherwise go IDLE, busy=0, snd_out=0.
- Note length: exactly duration*TICK_DIV cycles of busy per note (first PLAY cycle through last). Back-to-back notes have no gap cycle.
- Simultaneous end-of-note and addr1 write in the same cycle: the write is evaluated against pre-edge pending_valid.
  - If pending was empty, the written note becomes the next note and plays immediately.
  - If pending was full, the pending note plays and the write sets ovf.
- Counters never overflow: the phase counter is bounded by hp-1 and remaining by DUR_W.

Test Plan (TICK_DIV=4, DIV_W=8, DUR_W=8):
- Basic note: write hp=3, dur=2 -> busy high exactly 8 cycles starting the cycle after the write; snd_out rises after 3 PLAY cycles, toggles every 3 cycles; then busy=0, snd_out=0.
- Queueing:
  - Write note A (hp=2, dur=1), then note B (hp=5, dur=1), then note C during A -> C dropped, STATUS=0b111.
  - B starts the cycle after A's last cycle, busy never drops, total busy 8 cycles.
  - A second STATUS read returns 0b001 while B plays.
- Rest and zero duration:
  - hp=0, dur=3 -> snd_out stays 0, busy for 12 cycles.
  - Then write dur=0 -> busy stays 0, STATUS=0.
- Abort: start hp=2, dur=5, queue a second note, write CTRL=1 at cycle 6 -> next cycle busy=0, snd_out=0, STATUS=0, nothing further plays.
- Reset mid-note: pull rst low asynchronously (between edges) at cycle 5 of a dur=4 note -> snd_out/busy drop immediately; after release STATUS=0, the hp_stage readback effect is 0 (a new dur write produces a rest).
- Simultaneity: write a note on the exact end-of-note cycle with pending empty -> it plays with zero gap; repeat with pending full -> the pending note plays and ovf=1.

Source files
------------

// File: rtl/xtone_gen.sv
// Memory-mapped square-wave tone generator with a one-entry pending-note buffer.
// Each written (half-period, duration) pair plays for duration*TICK_DIV cycles on snd_out.
module xtone_gen #(
  parameter int DATA_W   = 32,
  parameter int DIV_W    = 24,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              snd_out,
  output logic              busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  hp_stage_q, hp_stage_d;
  logic [DIV_W-1:0]  hp_q, hp_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic [DIV_W-1:0]  phase_q, phase_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              snd_q, snd_d;
  logic [DIV_W-1:0]  pend_hp_q, pend_hp_d;
  logic [DUR_W-1:0]  pend_dur_q, pend_dur_d;
  logic              pend_vld_q, pend_vld_d;
  logic              ovf_q, ovf_d;

  logic             wr_hp, wr_dur, wr_ctrl, rd_status;
  logic             wr_note, abort, tick_wrap, end_note;
  logic [DUR_W-1:0] new_dur;
  logic             unused_bits;

  assign wr_hp       = sel & we & (addr == 2'd0);
  assign wr_dur      = sel & we & (addr == 2'd1);
  assign wr_ctrl     = sel & we & (addr == 2'd3);
  assign rd_status   = sel & ~we & (addr == 2'd2);
  assign new_dur     = data_in[DUR_W-1:0];
  assign wr_note     = wr_dur & (new_dur != '0);
  assign abort       = wr_ctrl & data_in[0];
  assign tick_wrap   = (tick_q == TICK_LAST);
  assign end_note    = (state_q == PLAY) & tick_wrap & (rem_q == DUR_W'(1));
  assign unused_bits = ^data_in;

  assign busy     = (state_q == PLAY);
  assign snd_out  = snd_q;
  assign data_out = rd_status ? {{(DATA_W-3){1'b0}}, ovf_q, pend_vld_q, busy} : '0;

  always_comb begin
    state_d    = state_q;
    hp_stage_d = wr_hp ? data_in[DIV_W-1:0] : hp_stage_q;
    hp_d       = hp_q;
    rem_d      = rem_q;
    phase_d    = phase_q;
    tick_d     = tick_q;
    snd_d      = snd_q;
    pend_hp_d  = pend_hp_q;
    pend_dur_d = pend_dur_q;
    pend_vld_d = pend_vld_q;
    // A status read clears ovf, but a same-cycle drop below re-sets it.
    ovf_d      = rd_status ? 1'b0 : ovf_q;

    if (abort) begin
      state_d    = IDLE;
      rem_d      = '0;
      phase_d    = '0;
      tick_d     = '0;
      snd_d      = 1'b0;
      pend_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          phase_d = '0;
          tick_d  = '0;
          snd_d   = 1'b0;
          rem_d   = '0;
          if (wr_note) begin
            state_d = PLAY;
            hp_d    = hp_stage_q;
            rem_d   = new_dur;
          end
        end
        PLAY: begin
          if (hp_q == '0) begin
            phase_d = '0;
            snd_d   = 1'b0;
          end else if (phase_q == hp_q - DIV_W'(1)) begin
            phase_d = '0;
            snd_d   = ~snd_q;
          end else begin
            phase_d = phase_q + DIV_W'(1);
          end
          tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
          if (tick_wrap) rem_d = rem_q - DUR_W'(1);

          // Decisions below use the pre-edge pending_valid.
          if (end_note) begin
            phase_d = '0;
            tick_d  = '0;
            snd_d   = 1'b0;
            if (pend_vld_q) begin
              hp_d       = pend_hp_q;
              rem_d      = pend_dur_q;
              pend_vld_d = 1'b0;
              if (wr_note) ovf_d = 1'b1;
            end else if (wr_note) begin
              hp_d  = hp_stage_q;
              rem_d = new_dur;
            end else begin
              state_d = IDLE;
              rem_d   = '0;
            end
          end else if (wr_note) begin
            if (pend_vld_q) begin
              ovf_d = 1'b1;
            end else begin
              pend_hp_d  = hp_stage_q;
              pend_dur_d = new_dur;
              pend_vld_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hp_stage_q <= '0;
      hp_q       <= '0;
      rem_q      <= '0;
      phase_q    <= '0;
      tick_q     <= '0;
      snd_q      <= 1'b0;
      pend_hp_q  <= '0;
      pend_dur_q <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_stage_q <= hp_stage_d;
      hp_q       <= hp_d;
      rem_q      <= rem_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      snd_q      <= snd_d;
      pend_hp_q  <= pend_hp_d;
      pend_dur_q <= pend_dur_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
